// File: rtl/spi_engine_mc.sv
// Multi-device SPI transfer engine with double-banked TX/RX byte buffers,
// programmable SCK divider, CPOL, filler-skipping read with timeout and abort.
module spi_engine_mc #(
    parameter int         NUM_DEVICES = 2,
    parameter int         BUF_DEPTH   = 512,
    parameter int         DIV_WIDTH   = 8,
    parameter logic [7:0] FILLER      = 8'hFF,
    parameter int         WAIT_LIMIT  = 4096,
    localparam int ADDR_W = $clog2(BUF_DEPTH),
    localparam int DEV_W  = (NUM_DEVICES > 1) ? $clog2(NUM_DEVICES) : 1,
    localparam int WCNT_W = $clog2(WAIT_LIMIT + 1)
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [ADDR_W-1:0]      BufAddr,
    input  logic [7:0]             BufWriteData,
    input  logic                   BufWrite,
    output logic [7:0]             BufReadData,
    input  logic                   Start,
    input  logic [ADDR_W-1:0]      Len,
    input  logic [1:0]             Mode,
    input  logic [DEV_W-1:0]       DevSel,
    input  logic [DIV_WIDTH-1:0]   Div,
    input  logic                   Cpol,
    input  logic                   BankSel,
    input  logic                   CsEnable,
    input  logic                   Abort,
    output logic                   Busy,
    output logic                   Done,
    output logic                   Timeout,
    output logic                   SpiClk,
    output logic                   SpiMosi,
    input  logic [NUM_DEVICES-1:0] SpiMiso,
    output logic [NUM_DEVICES-1:0] SpiCs_n
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_LEAD  = 3'd3;
    localparam logic [2:0] S_TRAIL = 3'd4;

    localparam logic [1:0] M_WRITE = 2'd0;
    localparam logic [1:0] M_WAIT  = 2'd3;

    logic [2:0]           state_q, state_d;
    logic [ADDR_W-1:0]    len_q, len_d;
    logic [1:0]           mode_q, mode_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic                 cpol_q, cpol_d;
    logic                 bank_q, bank_d;
    logic [DEV_W-1:0]     dev_q, dev_d;
    logic [ADDR_W-1:0]    pos_q, pos_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [2:0]           bit_q, bit_d;
    logic [7:0]           sr_q, sr_d;
    logic                 miso_q, miso_d;
    logic                 sck_q, sck_d;
    logic                 done_q, done_d;
    logic                 tout_q, tout_d;
    logic                 found_q, found_d;
    logic [WCNT_W-1:0]    fcnt_q, fcnt_d;
    logic [7:0]           tx_q;
    logic [7:0]           rd_q;
    logic                 rx_we;
    logic                 mosi;
    logic                 skip;

    logic [7:0] tx_mem [0:2*BUF_DEPTH-1];
    logic [7:0] rx_mem [0:2*BUF_DEPTH-1];

    // WaitAndRead discards filler bytes until the slave sends real data
    assign skip = (mode_q == M_WAIT) && !found_q && (sr_q == FILLER);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        mode_d  = mode_q;
        div_d   = div_q;
        cpol_d  = cpol_q;
        bank_d  = bank_q;
        dev_d   = dev_q;
        pos_d   = pos_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sr_d    = sr_q;
        miso_d  = miso_q;
        sck_d   = sck_q;
        done_d  = 1'b0;
        tout_d  = tout_q;
        found_d = found_q;
        fcnt_d  = fcnt_q;
        rx_we   = 1'b0;
        if (state_q == S_IDLE) begin
            bank_d = BankSel;
            dev_d  = DevSel;
            if (Start) begin
                len_d   = Len;
                mode_d  = Mode;
                div_d   = Div;
                cpol_d  = Cpol;
                sck_d   = Cpol;
                pos_d   = '0;
                fcnt_d  = '0;
                found_d = 1'b0;
                tout_d  = 1'b0;
                state_d = S_FETCH;
            end
        end else if (Abort) begin
            sck_d   = cpol_q;
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_FETCH: state_d = S_LOAD;
                S_LOAD: begin
                    sr_d    = tx_q;
                    miso_d  = SpiMiso[dev_q];
                    sck_d   = ~cpol_q;
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = S_LEAD;
                end
                S_LEAD: begin
                    if (cnt_q == div_q) begin
                        sr_d    = {sr_q[6:0], miso_q};
                        sck_d   = cpol_q;
                        cnt_d   = '0;
                        state_d = S_TRAIL;
                    end else begin
                        cnt_d = cnt_q + DIV_WIDTH'(1);
                    end
                end
                S_TRAIL: begin
                    if (cnt_q != div_q) begin
                        cnt_d = cnt_q + DIV_WIDTH'(1);
                    end else if (bit_q != 3'd7) begin
                        bit_d   = bit_q + 3'd1;
                        miso_d  = SpiMiso[dev_q];
                        sck_d   = ~cpol_q;
                        cnt_d   = '0;
                        state_d = S_LEAD;
                    end else if (skip) begin
                        fcnt_d = fcnt_q + WCNT_W'(1);
                        if (fcnt_q == WCNT_W'(WAIT_LIMIT - 1)) begin
                            tout_d  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_LOAD;
                        end
                    end else begin
                        found_d = 1'b1;
                        rx_we   = (mode_q != M_WRITE);
                        if (pos_q == len_q) begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            pos_d   = pos_q + ADDR_W'(1);
                            state_d = S_FETCH;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            mode_q  <= '0;
            div_q   <= '0;
            cpol_q  <= 1'b0;
            bank_q  <= 1'b0;
            dev_q   <= '0;
            pos_q   <= '0;
            cnt_q   <= '0;
            bit_q   <= '0;
            sr_q    <= '0;
            miso_q  <= 1'b0;
            sck_q   <= 1'b0;
            done_q  <= 1'b0;
            tout_q  <= 1'b0;
            found_q <= 1'b0;
            fcnt_q  <= '0;
            tx_q    <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            mode_q  <= mode_d;
            div_q   <= div_d;
            cpol_q  <= cpol_d;
            bank_q  <= bank_d;
            dev_q   <= dev_d;
            pos_q   <= pos_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sr_q    <= sr_d;
            miso_q  <= miso_d;
            sck_q   <= sck_d;
            done_q  <= done_d;
            tout_q  <= tout_d;
            found_q <= found_d;
            fcnt_q  <= fcnt_d;
            tx_q    <= tx_mem[{~bank_q, pos_q}];
            rd_q    <= rx_mem[{bank_q, BufAddr}];
        end
    end

    always_ff @(posedge Clk) begin
        if (BufWrite) tx_mem[{bank_q, BufAddr}] <= BufWriteData;
        if (rx_we) rx_mem[{~bank_q, pos_q}] <= sr_q;
    end

    // MOSI shows the TX byte's MSB already in LOAD so a CPHA=0 slave sees it
    always_comb begin
        mosi = 1'b1;
        if (!mode_q[0]) begin
            if (state_q == S_LOAD) mosi = tx_q[7];
            else if (state_q == S_LEAD || state_q == S_TRAIL) mosi = sr_q[7];
        end
    end

    always_comb begin
        SpiCs_n = '1;
        for (int i = 0; i < NUM_DEVICES; i++)
            SpiCs_n[i] = ~(CsEnable && (dev_q == DEV_W'(i)));
    end

    assign Busy        = (state_q != S_IDLE);
    assign Done        = done_q;
    assign Timeout     = tout_q;
    assign SpiClk      = sck_q;
    assign SpiMosi     = mosi;
    assign BufReadData = rd_q;

endmodule

// File: tb/tb_spi_engine_mc.sv
// Directed bench for spi_engine_mc with a small CPHA=0 slave model
// and MOSI loopback option.
module tb_spi_engine_mc;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic       Reset, BufWrite, Start, Cpol, BankSel, CsEnable, Abort;
    logic [3:0] BufAddr, Len;
    logic [7:0] BufWriteData, BufReadData, Div;
    logic [1:0] Mode, SpiMiso, SpiCs_n;
    logic       DevSel;
    logic       Busy, Done, Timeout, SpiClk, SpiMosi;

    int vecs = 0;
    int errs = 0;

    spi_engine_mc #(
        .NUM_DEVICES(2), .BUF_DEPTH(16), .DIV_WIDTH(8),
        .FILLER(8'hFF), .WAIT_LIMIT(4)
    ) dut (
        .Clk(Clk), .Reset(Reset), .BufAddr(BufAddr),
        .BufWriteData(BufWriteData), .BufWrite(BufWrite),
        .BufReadData(BufReadData), .Start(Start), .Len(Len),
        .Mode(Mode), .DevSel(DevSel), .Div(Div), .Cpol(Cpol),
        .BankSel(BankSel), .CsEnable(CsEnable), .Abort(Abort),
        .Busy(Busy), .Done(Done), .Timeout(Timeout),
        .SpiClk(SpiClk), .SpiMosi(SpiMosi), .SpiMiso(SpiMiso),
        .SpiCs_n(SpiCs_n)
    );

    logic [7:0]  slv_bytes [8];
    int          slv_n = 0;
    int          slv_gen = 0;
    int          seen_gen = 0;
    logic [7:0]  slv_sr = 8'hFF;
    int          slv_bit = 0;
    int          slv_idx = 0;
    logic        sck_prev = 1'b0;
    logic [15:0] mosi_cap = '0;
    int          lead_cnt = 0;
    logic        tb_loop = 1'b0;
    logic        tb_cpol = 1'b0;
    logic        tb_dev = 1'b0;
    logic        mb;

    assign mb = tb_loop ? SpiMosi : slv_sr[7];
    assign SpiMiso = tb_dev ? {mb, ~mb} : {~mb, mb};

    always @(negedge Clk) begin
        sck_prev <= SpiClk;
        if (slv_gen != seen_gen) begin
            seen_gen <= slv_gen;
            slv_idx  <= 0;
            slv_bit  <= 0;
            slv_sr   <= (slv_n > 0) ? slv_bytes[0] : 8'hFF;
            lead_cnt <= 0;
            mosi_cap <= '0;
        end else if (SpiClk != sck_prev) begin
            if (SpiClk != tb_cpol) begin
                lead_cnt <= lead_cnt + 1;
                mosi_cap <= {mosi_cap[14:0], SpiMosi};
            end else if (slv_bit == 7) begin
                slv_bit <= 0;
                slv_idx <= slv_idx + 1;
                slv_sr  <= (slv_idx + 1 < slv_n) ? slv_bytes[slv_idx + 1] : 8'hFF;
            end else begin
                slv_bit <= slv_bit + 1;
                slv_sr  <= {slv_sr[6:0], 1'b1};
            end
        end
    end

    function automatic logic [7:0] pat(input int i);
        return 8'(i * 29 + 7);
    endfunction

    task automatic set_slave(input logic [7:0] a, b, c, d, input int n);
        slv_bytes[0] = a; slv_bytes[1] = b;
        slv_bytes[2] = c; slv_bytes[3] = d;
        slv_n = n;
    endtask

    task automatic write_tx(input logic [3:0] a, input logic [7:0] d);
        @(negedge Clk);
        BankSel = 1'b1;
        @(negedge Clk);
        BufAddr = a; BufWriteData = d; BufWrite = 1'b1;
        @(negedge Clk);
        BufWrite = 1'b0;
    endtask

    task automatic read_rx(input logic [3:0] a, output logic [7:0] d);
        @(negedge Clk);
        BankSel = 1'b1; BufAddr = a;
        @(negedge Clk);
        @(negedge Clk);
        d = BufReadData;
    endtask

    task automatic do_start(input logic [1:0] m, input logic [3:0] l,
                            input logic dv, input logic [7:0] dd,
                            input logic cp);
        @(negedge Clk);
        Mode = m; Len = l; DevSel = dv; Div = dd; Cpol = cp;
        BankSel = 1'b0; tb_cpol = cp; tb_dev = dv; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        slv_gen = slv_gen + 1;
    endtask

    task automatic wait_end(input int max, output int n, output bit dn,
                            output int act);
        n = 0; dn = 0; act = 0;
        do begin
            @(negedge Clk);
            n++;
            if (Done) dn = 1;
            if (SpiClk != tb_cpol) act++;
        end while (Busy && n < max);
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        vecs++; if (Busy !== 1'b0) begin errs++; $display("FAIL rst_busy got %b want 0", Busy); end
        vecs++; if (Done !== 1'b0) begin errs++; $display("FAIL rst_done got %b want 0", Done); end
        vecs++; if (Timeout !== 1'b0) begin errs++; $display("FAIL rst_tout got %b want 0", Timeout); end
        vecs++; if (SpiClk !== 1'b0) begin errs++; $display("FAIL rst_sck got %b want 0", SpiClk); end
        vecs++; if (SpiMosi !== 1'b1) begin errs++; $display("FAIL rst_mosi got %b want 1", SpiMosi); end
        vecs++; if (SpiCs_n !== 2'b11) begin errs++; $display("FAIL rst_cs got %b want 11", SpiCs_n); end
        vecs++; if (BufReadData !== 8'h00) begin errs++; $display("FAIL rst_rd got %h want 00", BufReadData); end
        Reset = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_write();
        int n, act; bit dn;
        CsEnable = 1'b1;
        write_tx(4'd0, 8'hA5);
        write_tx(4'd1, 8'h3C);
        do_start(2'd0, 4'd1, 1'b1, 8'd0, 1'b0);
        vecs++; if (Busy !== 1'b1) begin errs++; $display("FAIL wr_busy got %b want 1", Busy); end
        vecs++; if (SpiCs_n !== 2'b01) begin errs++; $display("FAIL wr_cs got %b want 01", SpiCs_n); end
        wait_end(200, n, dn, act);
        vecs++; if (n !== 36) begin errs++; $display("FAIL wr_cycles got %0d want 36", n); end
        vecs++; if (dn !== 1'b1) begin errs++; $display("FAIL wr_done got %b want 1", dn); end
        vecs++; if (lead_cnt !== 16) begin errs++; $display("FAIL wr_edges got %0d want 16", lead_cnt); end
        vecs++; if (mosi_cap !== 16'hA53C) begin errs++; $display("FAIL wr_mosi got %h want a53c", mosi_cap); end
        @(negedge Clk);
        vecs++; if (Done !== 1'b0) begin errs++; $display("FAIL wr_pulse got %b want 0", Done); end
        vecs++; if (SpiCs_n !== 2'b01) begin errs++; $display("FAIL wr_cshold got %b want 01", SpiCs_n); end
    endtask

    task automatic test_exchange();
        int n, act; bit dn; logic [7:0] d;
        write_tx(4'd0, 8'h0F);
        write_tx(4'd1, 8'hF0);
        tb_loop = 1'b1;
        do_start(2'd2, 4'd1, 1'b0, 8'd3, 1'b1);
        vecs++; if (SpiClk !== 1'b1) begin errs++; $display("FAIL ex_idle got %b want 1", SpiClk); end
        wait_end(400, n, dn, act);
        vecs++; if (n !== 132) begin errs++; $display("FAIL ex_cycles got %0d want 132", n); end
        vecs++; if (act !== 64) begin errs++; $display("FAIL ex_halfper got %0d want 64", act); end
        vecs++; if (SpiClk !== 1'b1) begin errs++; $display("FAIL ex_sckend got %b want 1", SpiClk); end
        read_rx(4'd0, d);
        vecs++; if (d !== 8'h0F) begin errs++; $display("FAIL ex_rx0 got %h want 0f", d); end
        read_rx(4'd1, d);
        vecs++; if (d !== 8'hF0) begin errs++; $display("FAIL ex_rx1 got %h want f0", d); end
    endtask

    task automatic test_wait_read();
        int n, act; bit dn; logic [7:0] d;
        tb_loop = 1'b0;
        set_slave(8'hFF, 8'hFF, 8'hFF, 8'h5A, 4);
        do_start(2'd3, 4'd0, 1'b0, 8'd0, 1'b0);
        wait_end(400, n, dn, act);
        vecs++; if (dn !== 1'b1) begin errs++; $display("FAIL wr5a_done got %b want 1", dn); end
        vecs++; if (lead_cnt !== 32) begin errs++; $display("FAIL wr5a_edges got %0d want 32", lead_cnt); end
        vecs++; if (Timeout !== 1'b0) begin errs++; $display("FAIL wr5a_tout got %b want 0", Timeout); end
        read_rx(4'd0, d);
        vecs++; if (d !== 8'h5A) begin errs++; $display("FAIL wr5a_rx0 got %h want 5a", d); end
    endtask

    task automatic test_timeout();
        int n, act; bit dn;
        set_slave(8'hFF, 8'hFF, 8'hFF, 8'hFF, 0);
        do_start(2'd3, 4'd0, 1'b0, 8'd0, 1'b0);
        wait_end(400, n, dn, act);
        vecs++; if (Busy !== 1'b0) begin errs++; $display("FAIL to_busy got %b want 0", Busy); end
        vecs++; if (dn !== 1'b0) begin errs++; $display("FAIL to_done got %b want 0", dn); end
        vecs++; if (lead_cnt !== 32) begin errs++; $display("FAIL to_edges got %0d want 32", lead_cnt); end
        vecs++; if (Timeout !== 1'b1) begin errs++; $display("FAIL to_flag got %b want 1", Timeout); end
        repeat (3) @(negedge Clk);
        vecs++; if (Timeout !== 1'b1) begin errs++; $display("FAIL to_sticky got %b want 1", Timeout); end
        do_start(2'd0, 4'd0, 1'b0, 8'd0, 1'b0);
        vecs++; if (Timeout !== 1'b0) begin errs++; $display("FAIL to_clear got %b want 0", Timeout); end
        wait_end(400, n, dn, act);
    endtask

    task automatic test_full_bank();
        int n, act, bad; bit dn; logic [7:0] d;
        for (int i = 0; i < 16; i++) write_tx(4'(i), pat(i));
        tb_loop = 1'b1;
        do_start(2'd2, 4'd15, 1'b0, 8'd0, 1'b0);
        wait_end(1000, n, dn, act);
        vecs++; if (n !== 288) begin errs++; $display("FAIL fb_cycles got %0d want 288", n); end
        vecs++; if (dn !== 1'b1) begin errs++; $display("FAIL fb_done got %b want 1", dn); end
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            read_rx(4'(i), d);
            vecs++;
            if (d !== pat(i)) begin
                errs++;
                $display("FAIL fb_rx%0d got %h want %h", i, d, pat(i));
            end
        end
    endtask

    task automatic test_abort();
        bit dn; logic [7:0] d;
        tb_loop = 1'b0;
        set_slave(8'h11, 8'h22, 8'h33, 8'h44, 4);
        do_start(2'd1, 4'd3, 1'b1, 8'd0, 1'b0);
        dn = 0;
        for (int k = 2; k <= 46; k++) begin
            @(negedge Clk);
            if (Done) dn = 1;
            if (k == 5) begin Start = 1'b1; Mode = 2'd0; Len = 4'd0; end
            if (k == 6) begin
                Start = 1'b0;
                vecs++; if (Busy !== 1'b1) begin errs++; $display("FAIL ab_ignore got %b want 1", Busy); end
            end
            if (k == 46) Abort = 1'b1;
        end
        @(negedge Clk);
        Abort = 1'b0;
        vecs++; if (Busy !== 1'b0) begin errs++; $display("FAIL ab_busy got %b want 0", Busy); end
        vecs++; if (SpiClk !== 1'b0) begin errs++; $display("FAIL ab_sck got %b want 0", SpiClk); end
        vecs++; if (SpiMosi !== 1'b1) begin errs++; $display("FAIL ab_mosi got %b want 1", SpiMosi); end
        vecs++; if ((dn | Done) !== 1'b0) begin errs++; $display("FAIL ab_done got %b want 0", dn | Done); end
        read_rx(4'd0, d);
        vecs++; if (d !== 8'h11) begin errs++; $display("FAIL ab_rx0 got %h want 11", d); end
        read_rx(4'd1, d);
        vecs++; if (d !== 8'h22) begin errs++; $display("FAIL ab_rx1 got %h want 22", d); end
        read_rx(4'd2, d);
        vecs++; if (d !== pat(2)) begin errs++; $display("FAIL ab_rx2 got %h want %h", d, pat(2)); end
        read_rx(4'd3, d);
        vecs++; if (d !== pat(3)) begin errs++; $display("FAIL ab_rx3 got %h want %h", d, pat(3)); end
    endtask

    task automatic test_reset_mid();
        int n, act; bit dn; logic [7:0] d;
        CsEnable = 1'b0;
        tb_loop = 1'b1;
        do_start(2'd2, 4'd0, 1'b1, 8'd3, 1'b1);
        repeat (3) @(negedge Clk);
        vecs++; if (SpiClk !== 1'b0) begin errs++; $display("FAIL rm_lead got %b want 0", SpiClk); end
        Reset = 1'b1;
        @(negedge Clk);
        vecs++; if (Busy !== 1'b0) begin errs++; $display("FAIL rm_busy got %b want 0", Busy); end
        vecs++; if (Done !== 1'b0) begin errs++; $display("FAIL rm_done got %b want 0", Done); end
        vecs++; if (SpiClk !== 1'b0) begin errs++; $display("FAIL rm_sck got %b want 0", SpiClk); end
        vecs++; if (SpiMosi !== 1'b1) begin errs++; $display("FAIL rm_mosi got %b want 1", SpiMosi); end
        vecs++; if (SpiCs_n !== 2'b11) begin errs++; $display("FAIL rm_cs got %b want 11", SpiCs_n); end
        vecs++; if (BufReadData !== 8'h00) begin errs++; $display("FAIL rm_rd got %h want 00", BufReadData); end
        Reset = 1'b0;
        do_start(2'd2, 4'd0, 1'b0, 8'd0, 1'b0);
        wait_end(200, n, dn, act);
        vecs++; if (n !== 18) begin errs++; $display("FAIL rm_cycles got %0d want 18", n); end
        vecs++; if (dn !== 1'b1) begin errs++; $display("FAIL rm_fresh got %b want 1", dn); end
        read_rx(4'd0, d);
        vecs++; if (d !== pat(0)) begin errs++; $display("FAIL rm_rx0 got %h want %h", d, pat(0)); end
    endtask

    initial begin
        Reset = 1'b1; BufWrite = 1'b0; Start = 1'b0; Cpol = 1'b0;
        BankSel = 1'b0; CsEnable = 1'b0; Abort = 1'b0;
        BufAddr = '0; Len = '0; BufWriteData = '0; Div = '0;
        Mode = '0; DevSel = 1'b0;
        test_reset();
        test_write();
        test_exchange();
        test_wait_read();
        test_timeout();
        test_full_bank();
        test_abort();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

endmodule

// File: doc/spi_engine_mc.md
Name: spi_engine_mc

Overview:
- Single-clock, parametrised successor of the cartridge SPI transfer engine.
- Drives one shared SCK/MOSI bus to NUM_DEVICES chip-selected slaves: flash, TF card and future peripherals.
- Owns a double-banked TX/RX byte buffer. The CPU side sees one bank while the engine runs on the other.
- Adds a programmable SCK divider, CPOL, a wait-for-non-filler timeout and transfer abort.

Parameters:
NUM_DEVICES, 2, number of chip selects / MISO inputs
BUF_DEPTH, 512, bytes per bank (power of two); ADDR_W = clog2(BUF_DEPTH)
DIV_WIDTH, 8, width of SCK half-period divider
FILLER, 8'hFF, byte value skipped in WaitAndRead mode
WAIT_LIMIT, 4096, maximum filler bytes tolerated before timeout

Ports:
Clk  in  1  system clock, all logic on rising edge
Reset  in  1  synchronous, active-high
BufAddr  in  ADDR_W  CPU byte address into the bus-mapped bank
BufWriteData  in  8  CPU TX byte
BufWrite  in  1  write BufWriteData to TX[BankSel][BufAddr]
BufReadData  out  8  RX[BankSel][BufAddr], registered, 1-cycle latency
Start  in  1  one-cycle pulse; latches the configuration below
Len  in  ADDR_W  transfer length minus one (Len=0 means 1 byte)
Mode  in  2  0 Write, 1 Read, 2 Exchange, 3 WaitAndRead
DevSel  in  clog2(NUM_DEVICES)  target slave
Div  in  DIV_WIDTH  SCK half-period = Div+1 Clk cycles
Cpol  in  1  SCK idle level
BankSel  in  1  bus-mapped bank; the engine uses ~BankSel
CsEnable  in  1  software chip-select level
Abort  in  1  one-cycle pulse; terminates the transfer
Busy  out  1  transfer in progress
Done  out  1  one-cycle pulse on normal completion
Timeout  out  1  sticky; set on WaitAndRead limit, cleared by next accepted Start
SpiClk  out  1  SCK
SpiMosi  out  1  MOSI
SpiMiso  in  NUM_DEVICES  per-device MISO
SpiCs_n  out  NUM_DEVICES  active-low chip selects

Behaviour:
- Reset values: Busy=0, Done=0, Timeout=0, SpiClk=0, SpiMosi=1, SpiCs_n all 1, BufReadData=0, state IDLE, latched DevSel=0, Cpol=0, BankSel=0.
- Chip select: SpiCs_n[i] = ~(CsEnable && i==latched DevSel). It is independent of Busy, so software holds CS across multiple transfers.
- BankSel and DevSel are sampled only while IDLE. Changes during Busy take effect once IDLE is re-entered.
- Start while Busy is ignored. Start and Abort in the same cycle while IDLE: Start wins.
- States:
  - IDLE: Start → FETCH. Busy rises the cycle after Start. Len, Mode, Div and Cpol are latched; byte_pos=0; filler_cnt=0; Timeout cleared.
  - FETCH: TX RAM read of byte_pos, 1 cycle; then LOAD.
  - LOAD: shiftreg ← TX byte. MOSI = shiftreg[7] in Write/Exchange modes, constant 1 in Read/WaitAndRead. Next state LEAD.
  - LEAD: hold Div+1 cycles. On entry SCK goes to ~Cpol and MISO of DevSel is sampled into the shift LSB (CPHA=0). Next state TRAIL.
  - TRAIL: hold Div+1 cycles. SCK goes to Cpol and the shiftreg shifts left. Next state: LEAD if bit<7, else BYTE_END.
  - BYTE_END:
    - Every mode except WaitAndRead-before-first-non-filler: Read/Exchange/WaitAndRead store the RX byte at RX[~BankSel][byte_pos]. Then if byte_pos==Len → IDLE with Done pulse; else byte_pos+1 → FETCH.
    - WaitAndRead before the first non-filler byte: a received byte == FILLER is neither stored nor counted. filler_cnt+1; if it reaches WAIT_LIMIT → IDLE, Timeout=1, no Done. Otherwise the next byte is clocked without refetching TX.
- Abort, in any state other than IDLE: next cycle IDLE, SCK=Cpol, MOSI=1, Busy=0, no Done. RX bytes already stored are kept.
- byte_pos is ADDR_W bits. Len=BUF_DEPTH-1 transfers the full bank with no wrap.
- CPU reads and writes always target bank BankSel. The engine never writes that bank, so there are no port conflicts.
- Byte time = 16*(Div+1) + 2 Clk cycles. Done is asserted in the cycle the state returns to IDLE; Busy is 0 in that same cycle.
- Reset mid-transfer: immediate return to all reset values. RAM contents are undefined-preserved and are not cleared.

Test Plan:
1. Write mode, Div=0, Cpol=0, DevSel=1, BankSel=0: CPU writes TX[1][0..1]={A5,3C} via BankSel=1, then BankSel=0, Len=1, Start → MOSI shows 10100101 00111100 MSB-first. 16 SCK rising edges, Done after 36 cycles, SpiCs_n=2'b01 while CsEnable=1.
2. Exchange, Cpol=1, Div=3: slave loopback MISO=MOSI, TX {0F,F0} → RX[~BankSel] holds {0F,F0}. SCK idles high; half-period 4 cycles.
3. WaitAndRead, Len=0: slave returns FF,FF,FF,5A → only 5A stored at RX[0]; Done after 4 bytes clocked; Timeout=0.
4. WaitAndRead with MISO stuck 1, WAIT_LIMIT=4 → 4 bytes clocked, Timeout=1, Done never pulses, Busy falls. A following Start clears Timeout.
5. Abort in byte 2 of a Len=3 Read → Busy=0 next cycle, SCK=Cpol, RX[0..1] valid, RX[2..3] unchanged. A second Start during Busy is ignored.
6. Reset asserted mid-LEAD → all outputs at reset values next cycle. A fresh Len=0 transfer afterwards completes normally.
